// File: rtl/ex_stage_pkg.sv
// Shared CPU and control-unit types for the execute stage.
// Word/register widths, ALU opcodes, control-field encodings.
package cpu_types_pkg;
   localparam int WORD_W = 32;
   localparam int REG_W  = 5;
   localparam int SHAM_W = 5;
   localparam int IMM_W  = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [3:0] {
      ALU_SLL,
      ALU_SRL,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU
   } aluop_t;
endpackage

package control_unit_types_pkg;
   typedef enum logic [1:0] {ZEXT, SEXT, LUI} extop_t;
   typedef enum logic [1:0] {RD, RT, RA} regdst_t;
   typedef enum logic [1:0] {ALU, MEM, NPC} memtoreg_t;
   typedef enum logic [1:0] {FWD_BUS, FWD_EXMEM, FWD_WB} fwdsel_t;
endpackage

// File: rtl/ex_stage_alu.sv
// Shared integer ALU: arithmetic, logic, compare and shifts.
// Overflow flags signed add/sub only.
module alu
   import cpu_types_pkg::*;
(
   input  word_t  A,
   input  word_t  B,
   input  aluop_t ALUOp,
   output word_t  result,
   output logic   zero,
   output logic   overflow
);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      unique case (ALUOp)
         ALU_SLL:  result = A << B[SHAM_W-1:0];
         ALU_SRL:  result = A >> B[SHAM_W-1:0];
         ALU_ADD: begin
            result   = A + B;
            overflow = (A[WORD_W-1] == B[WORD_W-1]) &&
                       (result[WORD_W-1] != A[WORD_W-1]);
         end
         ALU_SUB: begin
            result   = A - B;
            overflow = (A[WORD_W-1] != B[WORD_W-1]) &&
                       (result[WORD_W-1] != A[WORD_W-1]);
         end
         ALU_AND:  result = A & B;
         ALU_OR:   result = A | B;
         ALU_XOR:  result = A ^ B;
         ALU_NOR:  result = ~(A | B);
         ALU_SLT:  result = {{(WORD_W-1){1'b0}}, $signed(A) < $signed(B)};
         ALU_SLTU: result = {{(WORD_W-1){1'b0}}, A < B};
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU drive, load-use detect
// and the EX/MEM pipeline register (stall/flush).
module ex_stage
   import cpu_types_pkg::*;
   import control_unit_types_pkg::*;
(
   input  logic               CLK,
   input  logic               nRST,
   input  logic               en,
   input  logic               flush,
   input  aluop_t             ALUOp,
   input  logic               ALUSrc,
   input  extop_t             ExtOp,
   input  regdst_t            RegDst,
   input  memtoreg_t          MemtoReg,
   input  logic               RegWEN,
   input  logic               dWENi,
   input  logic               dRENi,
   input  logic               halt,
   input  regbits_t           rs,
   input  regbits_t           rt,
   input  regbits_t           rd,
   input  logic [SHAM_W-1:0]  shamt,
   input  logic [IMM_W-1:0]   imm,
   input  word_t              busA,
   input  word_t              busB,
   input  word_t              npc,
   input  regbits_t           id_rs,
   input  regbits_t           id_rt,
   input  logic               wb_RegWEN,
   input  regbits_t           wb_wsel,
   input  word_t              wb_wdat,
   output logic               loaduse,
   output logic               exmem_RegWEN,
   output logic               exmem_dWEN,
   output logic               exmem_dREN,
   output logic               exmem_halt,
   output logic               exmem_zero,
   output memtoreg_t          exmem_MemtoReg,
   output regbits_t           exmem_wsel,
   output word_t              exmem_result,
   output word_t              exmem_stdata,
   output word_t              exmem_npc
);

   regbits_t wsel;
   word_t    extimm;
   word_t    ex_val;
   logic     ex_ok;
   fwdsel_t  fa_sel;
   fwdsel_t  fb_sel;
   word_t    fA;
   word_t    fB;
   logic     is_shift;
   word_t    alu_a;
   word_t    alu_b;
   word_t    alu_res;
   logic     alu_zero;
   logic     unused_ovf;

   always_comb begin
      wsel = rd;
      unique case (RegDst)
         RD:      wsel = rd;
         RT:      wsel = rt;
         RA:      wsel = 5'd31;
         default: wsel = rd;
      endcase
   end

   always_comb begin
      extimm = '0;
      unique case (ExtOp)
         ZEXT:    extimm = {16'b0, imm};
         SEXT:    extimm = {{16{imm[15]}}, imm};
         LUI:     extimm = {imm, 16'b0};
         default: extimm = '0;
      endcase
   end

   // A load in EX/MEM has no data yet; it is covered by the load-use stall.
   assign ex_ok  = exmem_RegWEN && (exmem_MemtoReg != MEM);
   assign ex_val = (exmem_MemtoReg == NPC) ? exmem_npc : exmem_result;

   always_comb begin
      fa_sel = FWD_BUS;
      if (rs != '0 && ex_ok && exmem_wsel == rs)
         fa_sel = FWD_EXMEM;
      else if (rs != '0 && wb_RegWEN && wb_wsel == rs)
         fa_sel = FWD_WB;
   end

   always_comb begin
      fb_sel = FWD_BUS;
      if (rt != '0 && ex_ok && exmem_wsel == rt)
         fb_sel = FWD_EXMEM;
      else if (rt != '0 && wb_RegWEN && wb_wsel == rt)
         fb_sel = FWD_WB;
   end

   always_comb begin
      unique case (fa_sel)
         FWD_EXMEM: fA = ex_val;
         FWD_WB:    fA = wb_wdat;
         default:   fA = busA;
      endcase
      unique case (fb_sel)
         FWD_EXMEM: fB = ex_val;
         FWD_WB:    fB = wb_wdat;
         default:   fB = busB;
      endcase
   end

   assign is_shift = (ALUOp == ALU_SLL || ALUOp == ALU_SRL) && !ALUSrc;
   assign alu_a    = is_shift ? fB : fA;
   assign alu_b    = is_shift ? {{(WORD_W-SHAM_W){1'b0}}, shamt}
                              : (ALUSrc ? extimm : fB);

   alu u_alu (
      .A        (alu_a),
      .B        (alu_b),
      .ALUOp    (ALUOp),
      .result   (alu_res),
      .zero     (alu_zero),
      .overflow (unused_ovf)
   );

   assign loaduse = dRENi && RegWEN && (wsel != '0) &&
                    (wsel == id_rs || wsel == id_rt);

   always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
         exmem_RegWEN   <= 1'b0;
         exmem_dWEN     <= 1'b0;
         exmem_dREN     <= 1'b0;
         exmem_halt     <= 1'b0;
         exmem_zero     <= 1'b0;
         exmem_MemtoReg <= ALU;
         exmem_wsel     <= '0;
         exmem_result   <= '0;
         exmem_stdata   <= '0;
         exmem_npc      <= '0;
      end else if (en) begin
         exmem_RegWEN   <= RegWEN;
         exmem_dWEN     <= dWENi;
         exmem_dREN     <= dRENi;
         exmem_halt     <= halt;
         exmem_zero     <= alu_zero;
         exmem_MemtoReg <= MemtoReg;
         exmem_wsel     <= wsel;
         exmem_result   <= alu_res;
         exmem_stdata   <= fB;
         exmem_npc      <= npc;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected
// EX/MEM contents and loaduse; a negedge monitor pops and compares.
module tb_ex_stage;
   import cpu_types_pkg::*;
   import control_unit_types_pkg::*;

   logic              CLK;
   logic              nRST;
   logic              en;
   logic              flush;
   aluop_t            ALUOp;
   logic              ALUSrc;
   extop_t            ExtOp;
   regdst_t           RegDst;
   memtoreg_t         MemtoReg;
   logic              RegWEN;
   logic              dWENi;
   logic              dRENi;
   logic              halt;
   regbits_t          rs;
   regbits_t          rt;
   regbits_t          rd;
   logic [SHAM_W-1:0] shamt;
   logic [IMM_W-1:0]  imm;
   word_t             busA;
   word_t             busB;
   word_t             npc;
   regbits_t          id_rs;
   regbits_t          id_rt;
   logic              wb_RegWEN;
   regbits_t          wb_wsel;
   word_t             wb_wdat;
   logic              loaduse;
   logic              exmem_RegWEN;
   logic              exmem_dWEN;
   logic              exmem_dREN;
   logic              exmem_halt;
   logic              exmem_zero;
   memtoreg_t         exmem_MemtoReg;
   regbits_t          exmem_wsel;
   word_t             exmem_result;
   word_t             exmem_stdata;
   word_t             exmem_npc;

   ex_stage dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .en             (en),
      .flush          (flush),
      .ALUOp          (ALUOp),
      .ALUSrc         (ALUSrc),
      .ExtOp          (ExtOp),
      .RegDst         (RegDst),
      .MemtoReg       (MemtoReg),
      .RegWEN         (RegWEN),
      .dWENi          (dWENi),
      .dRENi          (dRENi),
      .halt           (halt),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd),
      .shamt          (shamt),
      .imm            (imm),
      .busA           (busA),
      .busB           (busB),
      .npc            (npc),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .wb_RegWEN      (wb_RegWEN),
      .wb_wsel        (wb_wsel),
      .wb_wdat        (wb_wdat),
      .loaduse        (loaduse),
      .exmem_RegWEN   (exmem_RegWEN),
      .exmem_dWEN     (exmem_dWEN),
      .exmem_dREN     (exmem_dREN),
      .exmem_halt     (exmem_halt),
      .exmem_zero     (exmem_zero),
      .exmem_MemtoReg (exmem_MemtoReg),
      .exmem_wsel     (exmem_wsel),
      .exmem_result   (exmem_result),
      .exmem_stdata   (exmem_stdata),
      .exmem_npc      (exmem_npc)
   );

   typedef struct {
      logic [107:0] v;
      int           due;
      int           id;
   } exp_t;

   exp_t exq[$];
   exp_t luq[$];
   exp_t e;
   logic [107:0] last;
   logic [107:0] act;
   int cyc = 0;
   int nid = 0;
   int ntests = 0;
   int nfail = 0;
   logic done = 1'b0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   assign act = {exmem_RegWEN, exmem_dWEN, exmem_dREN, exmem_halt,
                 exmem_zero, exmem_MemtoReg, exmem_wsel,
                 exmem_result, exmem_stdata, exmem_npc};

   task automatic clr();
      nRST = 1'b1; en = 1'b1; flush = 1'b0;
      ALUOp = ALU_ADD; ALUSrc = 1'b0; ExtOp = SEXT;
      RegDst = RD; MemtoReg = ALU;
      RegWEN = 1'b0; dWENi = 1'b0; dRENi = 1'b0; halt = 1'b0;
      rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0;
      busA = '0; busB = '0; npc = '0;
      id_rs = '0; id_rt = '0;
      wb_RegWEN = 1'b0; wb_wsel = '0; wb_wdat = '0;
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
      clr();
   endtask

   task automatic ex(input logic rw, input logic dw, input logic dr,
                     input logic h, input logic z, input memtoreg_t m,
                     input regbits_t w, input word_t r, input word_t s,
                     input word_t n);
      exp_t x;
      x.v = {rw, dw, dr, h, z, m, w, r, s, n};
      x.due = cyc + 1;
      x.id = nid;
      nid++;
      last = x.v;
      exq.push_back(x);
   endtask

   task automatic ex_hold();
      exp_t x;
      x.v = last;
      x.due = cyc + 1;
      x.id = nid;
      nid++;
      exq.push_back(x);
   endtask

   task automatic ex_zero();
      ex(0, 0, 0, 0, 0, ALU, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic lu(input logic v);
      exp_t x;
      x.v = {107'b0, v};
      x.due = cyc;
      x.id = nid;
      nid++;
      luq.push_back(x);
   endtask

   always @(negedge CLK) begin
      while (exq.size() > 0 && exq[0].due <= cyc) begin
         e = exq.pop_front();
         ntests++;
         if (act !== e.v) begin
            nfail++;
            $display("FAIL exmem id=%0d got %h want %h", e.id, act, e.v);
         end
      end
      while (luq.size() > 0 && luq[0].due <= cyc) begin
         e = luq.pop_front();
         ntests++;
         if (loaduse !== e.v[0]) begin
            nfail++;
            $display("FAIL loaduse id=%0d got %b want %b",
                     e.id, loaduse, e.v[0]);
         end
      end
      if (done) begin
         ntests++;
         if (exq.size() != 0 || luq.size() != 0) begin
            nfail++;
            $display("FAIL drain got %0d left want 0",
                     exq.size() + luq.size());
         end
         $display("[TB] %0d tests run, %0d failed", ntests, nfail);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      nRST = 1'b0;
      // reset with arbitrary non-load inputs
      step(); nRST = 1'b0; busA = 32'h123; busB = 32'h456;
      rs = 5'd3; rt = 5'd4; RegWEN = 1'b1; halt = 1'b1; npc = 32'h4;
      ex_zero(); lu(1'b0);
      // addi $2,$0,5
      step(); ALUSrc = 1'b1; RegDst = RT; rt = 5'd2; imm = 16'd5;
      RegWEN = 1'b1; npc = 32'h104;
      ex(1, 0, 0, 0, 0, ALU, 5'd2, 32'd5, 32'd0, 32'h104);
      // add $3,$2,$2 via EX/MEM forward
      step(); rs = 5'd2; rt = 5'd2; rd = 5'd3; RegWEN = 1'b1;
      npc = 32'h108;
      ex(1, 0, 0, 0, 0, ALU, 5'd3, 32'd10, 32'd5, 32'h108);
      // addi $4,$0,7
      step(); ALUSrc = 1'b1; RegDst = RT; rt = 5'd4; imm = 16'd7;
      RegWEN = 1'b1; npc = 32'h10c;
      ex(1, 0, 0, 0, 0, ALU, 5'd4, 32'd7, 32'd0, 32'h10c);
      // EX/MEM beats WB on $4
      step(); rs = 5'd4; rd = 5'd5; busA = 32'd1; RegWEN = 1'b1;
      wb_RegWEN = 1'b1; wb_wsel = 5'd4; wb_wdat = 32'd9;
      ex(1, 0, 0, 0, 0, ALU, 5'd5, 32'd7, 32'd0, 32'd0);
      // write to $0 sits in EX/MEM
      step(); ALUSrc = 1'b1; RegDst = RT; imm = 16'd7; RegWEN = 1'b1;
      ex(1, 0, 0, 0, 0, ALU, 5'd0, 32'd7, 32'd0, 32'd0);
      // $0 at both sources: bus values used
      step(); rd = 5'd6; busA = 32'd20; busB = 32'd2; RegWEN = 1'b1;
      wb_RegWEN = 1'b1; wb_wsel = 5'd0; wb_wdat = 32'd9;
      ex(1, 0, 0, 0, 0, ALU, 5'd6, 32'd22, 32'd2, 32'd0);
      // A from WB, B from EX/MEM
      step(); rs = 5'd9; rt = 5'd6; rd = 5'd7; busA = 32'd1;
      RegWEN = 1'b1; wb_RegWEN = 1'b1; wb_wsel = 5'd9;
      wb_wdat = 32'd100;
      ex(1, 0, 0, 0, 0, ALU, 5'd7, 32'd122, 32'd22, 32'd0);
      // jal: link to $31
      step(); RegDst = RA; MemtoReg = NPC; RegWEN = 1'b1;
      npc = 32'h200;
      ex(1, 0, 0, 0, 1, NPC, 5'd31, 32'd0, 32'd0, 32'h200);
      // $31 forwarded from npc
      step(); rs = 5'd31; busA = 32'd5; rd = 5'd8; RegWEN = 1'b1;
      ex(1, 0, 0, 0, 0, ALU, 5'd8, 32'h200, 32'd0, 32'd0);
      // lw $5,0($1) with id_rt=5
      step(); ALUSrc = 1'b1; RegDst = RT; MemtoReg = MEM;
      RegWEN = 1'b1; dRENi = 1'b1; rs = 5'd1; rt = 5'd5;
      busA = 32'h1000; busB = 32'h55; id_rt = 5'd5;
      ex(1, 0, 1, 0, 0, MEM, 5'd5, 32'h1000, 32'h55, 32'd0);
      lu(1'b1);
      // same load, id_rt=6; load in EX/MEM not forwarded
      step(); ALUSrc = 1'b1; RegDst = RT; MemtoReg = MEM;
      RegWEN = 1'b1; dRENi = 1'b1; rs = 5'd1; rt = 5'd5;
      busA = 32'h1000; busB = 32'h66; id_rt = 5'd6;
      ex(1, 0, 1, 0, 0, MEM, 5'd5, 32'h1000, 32'h66, 32'd0);
      lu(1'b0);
      // lw $0 never stalls
      step(); ALUSrc = 1'b1; RegDst = RT; MemtoReg = MEM;
      RegWEN = 1'b1; dRENi = 1'b1; rs = 5'd1; rt = 5'd0;
      busA = 32'h1000; busB = 32'h77;
      ex(1, 0, 1, 0, 0, MEM, 5'd0, 32'h1000, 32'h77, 32'd0);
      lu(1'b0);
      // store with halt
      step(); ALUSrc = 1'b1; RegDst = RT; dWENi = 1'b1; halt = 1'b1;
      busA = 32'h40; imm = 16'd4; busB = 32'habc; npc = 32'h300;
      ex(0, 1, 0, 1, 0, ALU, 5'd0, 32'h44, 32'habc, 32'h300);
      // stall three cycles: hold
      for (int i = 0; i < 3; i++) begin
         step(); en = 1'b0; busA = 32'd1; busB = 32'd2; rd = 5'd9;
         RegWEN = 1'b1;
         ex_hold();
      end
      // flush during stall
      step(); en = 1'b0; flush = 1'b1; RegWEN = 1'b1; busA = 32'd3;
      ex_zero();
      step(); rs = 5'd10; rt = 5'd11; rd = 5'd12; busA = 32'd3;
      busB = 32'd4; RegWEN = 1'b1;
      ex(1, 0, 0, 0, 0, ALU, 5'd12, 32'd7, 32'd4, 32'd0);
      // flush and reset together
      step(); flush = 1'b1; nRST = 1'b0; busA = 32'd5; RegWEN = 1'b1;
      ex_zero();
      // immediates of 16'h8000
      step(); ALUSrc = 1'b1; ExtOp = SEXT; imm = 16'h8000;
      ex(0, 0, 0, 0, 0, ALU, 5'd0, 32'hFFFF8000, 32'd0, 32'd0);
      step(); ALUSrc = 1'b1; ExtOp = ZEXT; imm = 16'h8000;
      ex(0, 0, 0, 0, 0, ALU, 5'd0, 32'h00008000, 32'd0, 32'd0);
      step(); ALUSrc = 1'b1; ExtOp = LUI; imm = 16'h8000;
      ex(0, 0, 0, 0, 0, ALU, 5'd0, 32'h80000000, 32'd0, 32'd0);
      // shifts take rt and shamt
      step(); ALUOp = ALU_SLL; rt = 5'd1; busB = 32'd1; shamt = 5'd4;
      busA = 32'hffff;
      ex(0, 0, 0, 0, 0, ALU, 5'd0, 32'd16, 32'd1, 32'd0);
      step(); ALUOp = ALU_SRL; rt = 5'd1; busB = 32'h80; shamt = 5'd3;
      busA = 32'hffff;
      ex(0, 0, 0, 0, 0, ALU, 5'd0, 32'h10, 32'h80, 32'd0);
      // sub to zero sets the flag
      step(); ALUOp = ALU_SUB; rs = 5'd2; rt = 5'd3; busA = 32'd9;
      busB = 32'd9;
      ex(0, 0, 0, 0, 1, ALU, 5'd0, 32'd0, 32'd9, 32'd0);
      // reset during stall
      step(); en = 1'b0; nRST = 1'b0; RegWEN = 1'b1; busA = 32'd8;
      ex_zero();
      step();
      repeat (2) @(posedge CLK);
      done = 1'b1;
   end

endmodule
